// File: rtl/rr_arb_mux_pkg.sv
// Shared types and helpers for the 4-channel round-robin arbiter and mux.
package rr_arb_mux_pkg;

    localparam int unsigned N_CH   = 4;
    localparam int unsigned DATA_W = 4;

    typedef logic [1:0]        ch_idx_t;
    typedef logic [N_CH-1:0]   ch_vec_t;
    typedef logic [DATA_W-1:0] data_t;

    function automatic ch_idx_t next_idx(input ch_idx_t idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/mux_4_1.sv
// Plain combinational 4:1 data selector.
module mux_4_1
    import rr_arb_mux_pkg::*;
(
    input  data_t   i_d0,
    input  data_t   i_d1,
    input  data_t   i_d2,
    input  data_t   i_d3,
    input  ch_idx_t i_sel,
    output data_t   o_y
);

    always_comb begin
        o_y = i_d0;
        unique case (i_sel)
            2'd0: o_y = i_d0;
            2'd1: o_y = i_d1;
            2'd2: o_y = i_d2;
            2'd3: o_y = i_d3;
        endcase
    end

endmodule

// File: rtl/rr_pick_4.sv
// Combinational round-robin pick: scans ptr+1, ptr+2, ptr+3, ptr for the first request.
module rr_pick_4
    import rr_arb_mux_pkg::*;
(
    input  ch_vec_t i_req,
    input  ch_idx_t i_ptr,
    output ch_vec_t o_gnt,
    output ch_idx_t o_idx,
    output logic    o_any
);

    ch_idx_t w_cand;

    always_comb begin
        o_gnt  = '0;
        o_idx  = i_ptr;
        o_any  = 1'b0;
        w_cand = i_ptr;
        for (int k = 0; k < N_CH; k++) begin
            w_cand = next_idx(w_cand);
            if (!o_any && i_req[w_cand]) begin
                o_any = 1'b1;
                o_idx = w_cand;
            end
        end
        o_gnt[o_idx] = o_any;
    end

endmodule

// File: rtl/rr_arb_mux_4_1.sv
// Round-robin arbitrated 4:1 mux with a registered valid/ready output stage.
// Optional per-channel accept counters are enabled with RR_ARB_MUX_STATS_EN.
module rr_arb_mux_4_1
    import rr_arb_mux_pkg::*;
#(
    parameter logic [1:0]  RESET_PTR = 2'd3,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  req,
    input  logic [DATA_W-1:0] d0,
    input  logic [DATA_W-1:0] d1,
    input  logic [DATA_W-1:0] d2,
    input  logic [DATA_W-1:0] d3,
    output logic [N_CH-1:0]  gnt,
    output logic             out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]       out_sel,
`ifdef RR_ARB_MUX_STATS_EN
    input  logic             stats_clr,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3,
`endif
    input  logic             out_ready
);

    if (CNT_W == 0) begin : g_cnt_w_chk
        $error("CNT_W must be at least 1");
    end

    logic    r_valid;
    data_t   r_data;
    ch_idx_t r_sel;
    ch_idx_t r_ptr;

    ch_vec_t w_pick_gnt;
    ch_idx_t w_idx;
    logic    w_any;
    logic    w_can_load;
    logic    w_accept;
    data_t   w_mux;

    rr_pick_4 u_pick (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    mux_4_1 u_mux (
        .i_d0  (d0),
        .i_d1  (d1),
        .i_d2  (d2),
        .i_d3  (d3),
        .i_sel (w_idx),
        .o_y   (w_mux)
    );

    // Grant is suppressed during reset so no requester sees a phantom transfer.
    assign w_can_load = !r_valid || out_ready;
    assign w_accept   = w_can_load && w_any && !rst;
    assign gnt        = w_accept ? w_pick_gnt : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
            r_ptr   <= RESET_PTR;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_data  <= w_mux;
            r_sel   <= w_idx;
            r_ptr   <= w_idx;
        end else if (out_ready) begin
            // Drain with nothing to replace it; data and sel keep their last value.
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_sel   = r_sel;

`ifdef RR_ARB_MUX_STATS_EN
    logic [CNT_W-1:0] r_cnt [N_CH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (stats_clr) begin
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_accept && (r_cnt[w_idx] != '1)) begin
            r_cnt[w_idx] <= r_cnt[w_idx] + CNT_W'(1);
        end
    end

    assign cnt0 = r_cnt[0];
    assign cnt1 = r_cnt[1];
    assign cnt2 = r_cnt[2];
    assign cnt3 = r_cnt[3];
`endif

endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
// Self-checking bench for rr_arb_mux_4_1 against a scan-based round-robin reference model.
// Exercises the counters too when RR_ARB_MUX_STATS_EN is defined.
module tb_rr_arb_mux_4_1;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] d [4];
    logic [3:0] gnt;
    logic       out_valid;
    logic [3:0] out_data;
    logic [1:0] out_sel;
    logic       out_ready;
`ifdef RR_ARB_MUX_STATS_EN
    logic       stats_clr;
    logic [7:0] cnt [4];
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int         m_ptr;
    bit         m_valid;
    logic [3:0] m_data;
    int         m_sel;
    int         m_cnt [4];

    always #5 clk = ~clk;

    rr_arb_mux_4_1 #(
        .RESET_PTR (2'd3),
        .CNT_W     (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .d0        (d[0]),
        .d1        (d[1]),
        .d2        (d[2]),
        .d3        (d[3]),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
`ifdef RR_ARB_MUX_STATS_EN
        .stats_clr (stats_clr),
        .cnt0      (cnt[0]),
        .cnt1      (cnt[1]),
        .cnt2      (cnt[2]),
        .cnt3      (cnt[3]),
`endif
        .out_ready (out_ready)
    );

    function automatic int winner(input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (m_ptr + k) % 4;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_gnt();
        int w;
        if (rst) return 4'b0000;
        if (m_valid && !out_ready) return 4'b0000;
        w = winner(req);
        if (w < 0) return 4'b0000;
        return 4'(1 << w);
    endfunction

    task automatic model_reset();
        m_ptr   = 3;
        m_valid = 0;
        m_data  = 4'h0;
        m_sel   = 0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    // Advance one clock edge and update the model with the inputs present at that edge.
    task automatic tick();
        int w;
        @(posedge clk);
        if (!rst) begin
            w = (exp_gnt() != 4'b0000) ? winner(req) : -1;
`ifdef RR_ARB_MUX_STATS_EN
            if (stats_clr) begin
                for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            end else if (w >= 0 && m_cnt[w] < 255) begin
                m_cnt[w]++;
            end
`endif
            if (w >= 0) begin
                m_valid = 1;
                m_data  = d[w];
                m_sel   = w;
                m_ptr   = w;
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        out_ready = 1'b1;
        d[0] = 4'hA; d[1] = 4'hB; d[2] = 4'hC; d[3] = 4'hD;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_tests++;
            if (gnt !== 4'b0000 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold: gnt=%b valid=%b, want gnt=0000 valid=0", gnt, out_valid);
            end
            n_tests++;
            if (out_data !== 4'h0 || out_sel !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_regs: data=%h sel=%0d, want 0/0", out_data, out_sel);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL first_gnt: gnt=%b want 0001", gnt);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 4'hA || out_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL first_beat: valid=%b data=%h sel=%0d, want 1/a/0",
                     out_valid, out_data, out_sel);
        end
        tick();
    endtask

    task automatic test_rotate();
        logic [3:0] exp_rot;
        req = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            exp_rot = 4'(1 << ((m_ptr + 1) % 4));
            n_tests++;
            if (gnt !== exp_gnt() || gnt !== exp_rot) begin
                n_fail++;
                $display("FAIL rotate_gnt[%0d]: gnt=%b want %b", i, gnt, exp_rot);
            end
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== m_data || out_sel !== 2'(m_sel)) begin
                n_fail++;
                $display("FAIL rotate_data[%0d]: valid=%b data=%h sel=%0d, want 1/%h/%0d",
                         i, out_valid, out_data, out_sel, m_data, m_sel);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] held_data;
        logic [1:0] held_sel;
        req = 4'b1111;
        out_ready = 1'b0;
        held_data = out_data;
        held_sel  = out_sel;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (gnt !== 4'b0000 || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_gnt[%0d]: gnt=%b valid=%b, want 0000/1", i, gnt, out_valid);
            end
            n_tests++;
            if (out_data !== held_data || out_sel !== held_sel) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: data=%h sel=%0d, want %h/%0d",
                         i, out_data, out_sel, held_data, held_sel);
            end
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (gnt !== 4'(1 << ((held_sel + 1) % 4))) begin
            n_fail++;
            $display("FAIL stall_release_gnt: gnt=%b want %b", gnt, 4'(1 << ((held_sel + 1) % 4)));
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== d[(held_sel + 1) % 4]) begin
            n_fail++;
            $display("FAIL stall_release_data: valid=%b data=%h want 1/%h",
                     out_valid, out_data, d[(held_sel + 1) % 4]);
        end
        tick();
    endtask

    task automatic test_patterns();
        logic [3:0] pats [3];
        int         lens [3];
        pats[0] = 4'b0100; lens[0] = 4;
        pats[1] = 4'b0101; lens[1] = 6;
        pats[2] = 4'b0000; lens[2] = 3;
        out_ready = 1'b1;
        for (int p = 0; p < 3; p++) begin
            req = pats[p];
            for (int i = 0; i < lens[p]; i++) begin
                @(negedge clk);
                n_tests++;
                if (gnt !== exp_gnt()) begin
                    n_fail++;
                    $display("FAIL pattern_gnt[%b/%0d]: gnt=%b want %b", pats[p], i, gnt, exp_gnt());
                end
                n_tests++;
                if (out_valid !== m_valid || (m_valid && (out_data !== m_data || out_sel !== 2'(m_sel)))) begin
                    n_fail++;
                    $display("FAIL pattern_out[%b/%0d]: valid=%b data=%h sel=%0d, want %b/%h/%0d",
                             pats[p], i, out_valid, out_data, out_sel, m_valid, m_data, m_sel);
                end
                tick();
            end
        end
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pattern_drain: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_async_reset();
        req = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b gnt=%b, want 0/0000", out_valid, gnt);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL async_restart: gnt=%b want 0001", gnt);
        end
        tick();
    endtask

    task automatic test_random();
        int wait_acc [4];
        for (int i = 0; i < 4; i++) wait_acc[i] = 0;
        for (int c = 0; c < 400; c++) begin
            req = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) d[i] = 4'($urandom_range(0, 15));
            @(negedge clk);
            n_tests++;
            if (gnt !== exp_gnt()) begin
                n_fail++;
                $display("FAIL random_gnt[%0d]: gnt=%b want %b", c, gnt, exp_gnt());
            end
            n_tests++;
            if (out_valid !== m_valid || (m_valid && (out_data !== m_data || out_sel !== 2'(m_sel)))) begin
                n_fail++;
                $display("FAIL random_out[%0d]: valid=%b data=%h sel=%0d, want %b/%h/%0d",
                         c, out_valid, out_data, out_sel, m_valid, m_data, m_sel);
            end
            for (int i = 0; i < 4; i++) begin
                if (!req[i] || gnt[i]) begin
                    wait_acc[i] = 0;
                end else if (gnt != 4'b0000) begin
                    wait_acc[i]++;
                    n_tests++;
                    if (wait_acc[i] > 3) begin
                        n_fail++;
                        $display("FAIL starvation ch%0d: %0d accepts passed, want <= 3", i, wait_acc[i]);
                    end
                end
            end
            tick();
        end
    endtask

`ifdef RR_ARB_MUX_STATS_EN
    task automatic test_stats();
        req = 4'b0000;
        out_ready = 1'b1;
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        req = 4'b0010;
        for (int i = 0; i < 300; i++) tick();
        @(negedge clk);
        n_tests++;
        if (cnt[1] !== 8'd255 || cnt[0] !== 8'd0 || cnt[2] !== 8'd0 || cnt[3] !== 8'd0) begin
            n_fail++;
            $display("FAIL stats_sat: cnt=%0d/%0d/%0d/%0d want 0/255/0/0", cnt[0], cnt[1], cnt[2], cnt[3]);
        end
        n_tests++;
        if (32'(cnt[1]) !== m_cnt[1]) begin
            n_fail++;
            $display("FAIL stats_model: cnt1=%0d want %0d", cnt[1], m_cnt[1]);
        end
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        @(negedge clk);
        n_tests++;
        if (cnt[1] !== 8'd0) begin
            n_fail++;
            $display("FAIL stats_clr_wins: cnt1=%0d want 0", cnt[1]);
        end
        tick();
    endtask
`endif

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) d[i] = 4'h0;
`ifdef RR_ARB_MUX_STATS_EN
        stats_clr = 1'b0;
`endif
        test_reset();
        test_rotate();
        test_backpressure();
        test_patterns();
        test_async_reset();
        test_random();
`ifdef RR_ARB_MUX_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux_4_1.md
Name: rr_arb_mux_4_1

Overview:
Upstream stage that drives a 4:1 data mux with a round-robin arbiter. Four 4-bit requesters compete for one registered output channel. The block picks a winner, generates the 2-bit select, passes the winning data through mux_4_1, and captures it in an output register with a valid/ready handshake. Downstream consumers see one beat per cycle, plus the source index of each beat.

Parameters:
- RESET_PTR, default 3: value of the last-grant pointer after reset. With the default, the first pick after reset starts the scan at channel 0.
- CNT_W, default 8: width of the per-channel grant counters. Used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  4  per-channel request; req[i] qualifies di
- d0, d1, d2, d3  in  4 each  channel data
- gnt  out  4  one-hot combinational grant; transfer on channel i when req[i] & gnt[i]
- out_valid  out  1  output register holds a beat
- out_data  out  4  registered data of the held beat
- out_sel  out  2  registered source index of the held beat
- out_ready  in  1  downstream accepts; beat leaves when out_valid & out_ready

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_sel=0, ptr=RESET_PTR.
  - gnt forced to 0 while rst is high.
- can_load = !out_valid | out_ready.
- Pick (combinational): scan ptr+1, ptr+2, ptr+3, ptr (mod 4). The first index with req set is the winner.
- gnt:
  - gnt = onehot(winner) when can_load and |req; otherwise gnt = 0.
  - gnt is never more than one-hot.
- Accept, at the clock edge when |gnt:
  - out_data <= mux_4_1(d0..d3, sel=winner).
  - out_sel <= winner; out_valid <= 1; ptr <= winner.
  - Latency is 1 cycle from accept to out_valid.
- Drain without accept: if out_valid & out_ready and no req, out_valid <= 0. Data and sel keep their last value.
- Simultaneous drain and accept: the new beat replaces the old one in the same edge. Sustained throughput is 1 beat/cycle.
- Backpressure (out_valid & !out_ready):
  - gnt=0 and ptr is held.
  - out_data and out_sel are stable until the handshake completes.
- Requesters may deassert req without being granted. No fairness credit is kept for withdrawn requests. di must be valid whenever req[i]=1.
- ptr moves only on accept, so idle cycles do not skew fairness.
- Starvation bound: a continuously asserted req[i] is granted within 4 accepts.
- Reset mid-operation: out_valid drops immediately, without waiting for a clock edge. The held beat is discarded and ptr returns to RESET_PTR.

Optional Feature:
- Macro: RR_ARB_MUX_STATS_EN.
- Defined:
  - Adds input stats_clr (1 bit).
  - Adds outputs cnt0..cnt3 (CNT_W each), the per-channel accept counters.
  - Counters increment on each accept of their channel and saturate at all-ones.
  - Reset and stats_clr set them to 0. stats_clr wins over a same-cycle accept.
- Undefined: these ports and counters do not exist, and the rest of the behaviour is identical.

Decomposition:
- Package rr_arb_mux_pkg:
  - N_CH=4, DATA_W=4.
  - typedef ch_idx_t (logic [1:0]), typedef ch_vec_t (logic [3:0]).
  - Function next_idx(ch_idx_t) returning the index +1 with mod-4 wrap.
- Sub-module rr_pick_4: purely combinational. Inputs req and ptr; outputs one-hot grant, index and any. The top instantiates rr_pick_4 and the existing mux_4_1, and owns the registers and counters.

Test Plan:
1. Hold rst=1 with req=1111 → gnt=0000 and out_valid=0. Release rst with out_ready=1 and d0..d3=A,B,C,D → first gnt=0001, next cycle out_data=A, out_sel=0.
2. req=1111 and out_ready=1 constant → gnt rotates 0001, 0010, 0100, 1000, 0001. out_data reads A, B, C, D, A on consecutive cycles with no bubbles.
3. out_ready=0 while out_valid=1 holding B → gnt=0000, out_data=B and ptr stay stable for 5 cycles. Raise out_ready → C is loaded on the same edge and out_valid stays 1.
4. req=0100 only → ch2 granted every cycle. Then req=0101 with ptr=2 → ch0 then ch2 alternate. Then req=0000 → out_valid drops one cycle after the last drain.
5. Assert rst asynchronously mid-stream → out_valid=0 before the next clk edge. After release the scan restarts at ch0.
6. With RR_ARB_MUX_STATS_EN and CNT_W=8: 300 accepts on ch1 → cnt1=255 while the other counters stay at 0. stats_clr in the same cycle as a ch1 accept → cnt1=0 next cycle.
